// File: rtl/gf_pkg.sv
// Shared types and width helpers for the carry-less multiplier.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_clmul_state_t;

  // Unreduced product width for an m-bit field
  function automatic int gf_prod_w(input int dw);
    return 2 * dw;
  endfunction

  // Iteration counter width
  function automatic int gf_cnt_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/gf_clmul_seq.sv
// Sequential GF(2)[x] multiplier: one multiplier bit per cycle, unreduced
// 2*DATA_WIDTH product handed to the reduction stage over valid/ready.
// Optional macro GF_CLMUL_EARLY_EXIT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (same result, operand-dependent latency).
module gf_clmul_seq
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             a_in,
  input  logic [DATA_WIDTH-1:0]             b_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [gf_prod_w(DATA_WIDTH)-1:0]  product,
  output logic                              busy
);

  localparam int PW = gf_prod_w(DATA_WIDTH);
  localparam int CW = gf_cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  gf_clmul_state_t       state_q, state_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [PW-1:0]         a_sh_q, a_sh_d;
  logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_iter;

  // Next-state and datapath: load in IDLE, shift/XOR in RUN, hold in DONE
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    last_iter = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = PW'(a_in);
          b_sh_d  = b_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (b_sh_q[0]) acc_d = acc_q ^ a_sh_q;
        a_sh_d    = a_sh_q << 1;
        b_sh_d    = b_sh_q >> 1;
        last_iter = (cnt_q == CNT_LAST);
`ifdef GF_CLMUL_EARLY_EXIT_EN
        // No set bits left above the current one: the product is final
        if ((b_sh_q >> 1) == '0) last_iter = 1'b1;
`endif
        // Counter parks on the last value instead of wrapping
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight product
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode state only; product comes straight off acc
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign product   = acc_q;

endmodule

// File: doc/gf_clmul_seq.md
# gf_clmul_seq

Sequential carry-less (GF(2)[x]) polynomial multiplier that sits directly upstream of the reduction stage. It multiplies two DATA_WIDTH-bit binary polynomials one multiplier bit per cycle. It presents the 2*DATA_WIDTH-bit unreduced product on a valid/ready interface, which the reduction stage consumes as its reduction input.

## Interface
- DATA_WIDTH, 32, operand width in bits (field degree m); must be ≥ 2
- clk  input  1  rising-edge clock
- resetn  input  1  reset; one clock, asynchronous and active-low
- in_valid  input  1  operands a_in/b_in are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  DATA_WIDTH  multiplicand polynomial, bit i = coefficient of x^i
- b_in  input  DATA_WIDTH  multiplier polynomial, same encoding
- out_valid  output  1  product valid, held until taken
- out_ready  input  1  downstream (reduction) accepts product
- product  output  2*DATA_WIDTH  carry-less product a·b; bit 2*DATA_WIDTH-1 always 0
- busy  output  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load a_sh ← zero-extended a_in, b_sh ← b_in, acc ← 0, cnt ← 0, then go to RUN.
- RUN, each cycle:
  - if b_sh[0]: acc ← acc ^ a_sh.
  - a_sh ← a_sh << 1; b_sh ← b_sh >> 1; cnt ← cnt+1.
  - When cnt == DATA_WIDTH-1 on this cycle, go to DONE.
- DONE:
  - out_valid=1, product=acc, held stable.
  - On out_ready, go to IDLE.
- Arithmetic: XOR only, no carries. a_sh and acc are 2*DATA_WIDTH bits; cnt is $clog2(DATA_WIDTH) bits; nothing wraps.
- in_valid while not in IDLE: ignored (in_ready=0). Operands are not captured and not queued.
- a_in or b_in zero: the computation runs normally and the result is 0.
- Reset:
  - Reset asserted at any time, including mid-RUN or in DONE: state=IDLE immediately.
  - acc, a_sh, b_sh, cnt all clear to 0.
  - The in-flight result is lost; no out_valid is produced for it.
- Reset values: in_ready=1 (after reset deasserts), out_valid=0, busy=0, product=0.

## Timing
- Acceptance edge T (in_valid & in_ready): RUN from T.
- out_valid rises after edge T+DATA_WIDTH (latency DATA_WIDTH cycles, macro off).
- in_ready combinational from state; out_valid and busy combinational from state; product registered (acc).
- No combinational path from in_valid or out_ready to any output.
- Transfer on out_ready & out_valid at edge U: IDLE from U. The next acceptance is possible at edge U+1, giving a throughput of one product per DATA_WIDTH+2 cycles when out_ready is tied high.
- out_ready low in DONE: out_valid and product held indefinitely.

## Configuration
- GF_CLMUL_EARLY_EXIT_EN defined:
  - RUN also exits to DONE at the edge where the shifted b_sh becomes 0.
  - Latency = max(1, index of MSB of b_in + 1) cycles; b_in=0 gives 1 cycle.
  - Result is identical.
- Undefined: fixed latency DATA_WIDTH regardless of operands.

## Structure
- Shared package gf_pkg:
  - state enum gf_clmul_state_t {IDLE, RUN, DONE}.
  - localparam function for product width (2*DATA_WIDTH).
  - counter width ($clog2(DATA_WIDTH)).
- No sub-module: FSM and shift/XOR datapath live in one module.
- Instantiated ahead of the reduction stage; its product feeds that stage's reduction input.

## Test plan
- Reset, then a_in=0x3, b_in=0x3, out_ready=1 → out_valid after 32 cycles, product=0x0000000000000005; in_ready back high next cycle.
- a_in=0xFFFFFFFF, b_in=0xFFFFFFFF → product=0x5555555555555555.
- a_in=0x80000000, b_in=0x80000000 → product=0x4000000000000000; bit 63 = 0.
- Backpressure: out_ready low 5 cycles after out_valid → product and out_valid stable throughout, in_ready=0. A second in_valid during this window is not accepted.
- resetn pulsed low at cycle 10 of RUN → out_valid=0, busy=0, product=0 immediately. The next operation a_in=0x5, b_in=0x7 returns 0x1B.
- With GF_CLMUL_EARLY_EXIT_EN: b_in=0x1, a_in=0x12345678 → out_valid after 1 cycle, product=0x12345678. b_in=0 → 1 cycle, product=0.
